kw_schedule_quad: RTL and testbench

- Produces the SHA-256 message schedule for the four-round fused compression stage.
- Accepts one 512-bit padded block.
- Emits 16 consecutive quads of pre-added round constants, KWt = K[t] + W[t] mod 2^32, for t = 4q..4q+3, one quad per handshake.
- Drives the KW0_in..KW3_in inputs of the compression quad, which latches them on its own clock edge.

---
 rtl/sha256_pkg.sv | 27 ++
 rtl/sched_word.sv | 14 +
 rtl/kw_schedule_quad.sv | 89 ++++++++
 tb/tb_kw_schedule_quad.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 schedule constants, sigma functions and FSM state type
package sha256_pkg;

  localparam int WORDBITS = 32;

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sched_word.sv
// rtl/sched_word.sv - one expanded schedule word from its four recurrence taps
module sched_word
  import sha256_pkg::*;
(
  input  logic [WORDBITS-1:0] w2,
  input  logic [WORDBITS-1:0] w7,
  input  logic [WORDBITS-1:0] w15,
  input  logic [WORDBITS-1:0] w16,
  output logic [WORDBITS-1:0] nw
);

  assign nw = small_sigma1(w2) + w7 + small_sigma0(w15) + w16;

endmodule

// File: rtl/kw_schedule_quad.sv
// rtl/kw_schedule_quad.sv - SHA-256 message schedule emitting K+W four rounds per handshake
module kw_schedule_quad #(
  parameter int WORDBITS = 32,
  parameter int MSGWORDS = 16,
  parameter int QUADS    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         msg_valid,
  output logic                         msg_ready,
  input  logic [MSGWORDS*WORDBITS-1:0] msg_in,
  output logic                         kw_valid,
  input  logic                         kw_ready,
  output logic [WORDBITS-1:0]          kw0_out,
  output logic [WORDBITS-1:0]          kw1_out,
  output logic [WORDBITS-1:0]          kw2_out,
  output logic [WORDBITS-1:0]          kw3_out,
  output logic [3:0]                   kw_quad,
  output logic                         kw_last
);
  import sha256_pkg::*;

  state_t              state, state_nxt;
  logic [3:0]          q;
  logic [WORDBITS-1:0] win [MSGWORDS];
  logic [WORDBITS-1:0] n   [4];
  logic                last_q, load, xfer;

  assign last_q = (q == 4'(QUADS - 1));
  assign load   = msg_valid & msg_ready;
  assign xfer   = kw_valid & kw_ready;

  // N2 and N3 take their t-2 term from N0 and N1 of the same quad
  sched_word u_n0 (.w2(win[14]), .w7(win[9]),  .w15(win[1]), .w16(win[0]), .nw(n[0]));
  sched_word u_n1 (.w2(win[15]), .w7(win[10]), .w15(win[2]), .w16(win[1]), .nw(n[1]));
  sched_word u_n2 (.w2(n[0]),    .w7(win[11]), .w15(win[3]), .w16(win[2]), .nw(n[2]));
  sched_word u_n3 (.w2(n[1]),    .w7(win[12]), .w15(win[4]), .w16(win[3]), .nw(n[3]));

  always_comb begin
    state_nxt = state;
    msg_ready = 1'b0;
    kw_valid  = 1'b0;
    kw_last   = 1'b0;
    kw_quad   = 4'd0;
    kw0_out   = '0;
    kw1_out   = '0;
    kw2_out   = '0;
    kw3_out   = '0;
    case (state)
      IDLE: begin
        msg_ready = 1'b1;
        if (msg_valid) state_nxt = RUN;
      end
      RUN: begin
        kw_valid = 1'b1;
        kw_quad  = q;
        kw_last  = last_q;
        kw0_out  = K[{q, 2'd0}] + win[0];
        kw1_out  = K[{q, 2'd1}] + win[1];
        kw2_out  = K[{q, 2'd2}] + win[2];
        kw3_out  = K[{q, 2'd3}] + win[3];
        // the last-quad transfer doubles as the load slot for the next block
        if (kw_ready && last_q) begin
          msg_ready = 1'b1;
          if (!msg_valid) state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      q     <= 4'd0;
      for (int j = 0; j < MSGWORDS; j++) win[j] <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        q <= 4'd0;
        for (int j = 0; j < MSGWORDS; j++) win[j] <= msg_in[WORDBITS*j +: WORDBITS];
      end else if (xfer && !last_q) begin
        q <= q + 4'd1;
        for (int j = 0; j < MSGWORDS - 4; j++) win[j] <= win[j+4];
        for (int k = 0; k < 4; k++) win[MSGWORDS-4+k] <= n[k];
      end
    end
  end

endmodule

// File: tb/tb_kw_schedule_quad.sv
// tb/tb_kw_schedule_quad.sv - directed self-checking bench for kw_schedule_quad
module tb_kw_schedule_quad;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         msg_valid;
  logic         msg_ready;
  logic [511:0] msg_in;
  logic         kw_valid;
  logic         kw_ready;
  logic [31:0]  kw0_out, kw1_out, kw2_out, kw3_out;
  logic [3:0]   kw_quad;
  logic         kw_last;

  int total = 0;
  int bad   = 0;

  logic [31:0] kt   [64];
  logic [31:0] expv [128];
  logic [31:0] cap  [128];
  logic [31:0] ref_abc [64];
  logic [511:0] blk_abc, blk_ones;

  typedef struct {
    string       name;
    bit          ones;
    int          t;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  kw_schedule_quad dut (
    .clk(clk), .rst_n(rst_n), .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_in(msg_in),
    .kw_valid(kw_valid), .kw_ready(kw_ready), .kw0_out(kw0_out), .kw1_out(kw1_out),
    .kw2_out(kw2_out), .kw3_out(kw3_out), .kw_quad(kw_quad), .kw_last(kw_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  task automatic model(input logic [511:0] b, input int base);
    logic [31:0] w [64];
    for (int t = 0; t < 16; t++) w[t] = b[32*t +: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int t = 0; t < 64; t++) expv[base+t] = kt[t] + w[t];
  endtask

  task automatic cmp_model(input string nm, input int base);
    for (int t = 0; t < 64; t++) chk($sformatf("%s_kw%0d", nm, t), 160'(cap[base+t]), 160'(expv[base+t]));
  endtask

  // Feeds nblk blocks (msg_valid held until all accepted) and captures every transferred quad.
  task automatic run(input logic [511:0] b0, input logic [511:0] b1, input int nblk, input bit stall);
    int accepts = 0, taken = 0, cyc = 0, pulses = 0, gaps = 0;
    bit held = 0;
    logic [131:0] hv;
    @(negedge clk);
    msg_valid = 1'b1;
    msg_in    = b0;
    kw_ready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    while (taken < 16 * nblk && cyc < 2000) begin
      #1;
      if (kw_valid) begin
        if (held) chk("stall_hold", 160'({kw0_out, kw1_out, kw2_out, kw3_out, kw_quad}), 160'(hv));
        if (kw_ready) begin
          chk("quad_seq", 160'(kw_quad), 160'(taken % 16));
          chk("kw_last", 160'(kw_last), 160'((taken % 16) == 15));
          cap[4*taken]   = kw0_out;
          cap[4*taken+1] = kw1_out;
          cap[4*taken+2] = kw2_out;
          cap[4*taken+3] = kw3_out;
          taken++;
          held = 0;
        end else begin
          held = 1;
          hv = {kw0_out, kw1_out, kw2_out, kw3_out, kw_quad};
        end
        if (msg_ready) pulses++;
      end else if (taken > 0) begin
        gaps++;
      end
      if (msg_valid && msg_ready) accepts++;
      @(negedge clk);
      cyc++;
      if (accepts >= nblk) msg_valid = 1'b0;
      else if (accepts == 1) msg_in = b1;
      kw_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    msg_valid = 1'b0;
    chk("quads_taken", 160'(taken), 160'(16 * nblk));
    chk("accepts", 160'(accepts), 160'(nblk));
    chk("ready_pulses", 160'(pulses), 160'(nblk));
    chk("no_bubble", 160'(gaps), 160'(0));
  endtask

  initial begin
    kt = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    vecs = '{
      '{"abc_q0_kw0", 1'b0, 0,  32'hA3EC9318},
      '{"abc_q0_kw1", 1'b0, 1,  32'h71374491},
      '{"abc_q0_kw2", 1'b0, 2,  32'hB5C0FBCF},
      '{"abc_q0_kw3", 1'b0, 3,  32'hE9B5DBA5},
      '{"abc_q3_kw2", 1'b0, 14, 32'h9BDC06A7},
      '{"abc_q3_kw3", 1'b0, 15, 32'hC19BF18C},
      '{"abc_q4_kw0", 1'b0, 16, 32'h45FDCD41},
      '{"abc_q4_kw1", 1'b0, 17, 32'hEFCD4786},
      '{"ones_q0_kw0", 1'b1, 0, 32'h428A2F97},
      '{"ones_q4_kw0", 1'b1, 16, 32'h04DB69BD}
    };
    blk_abc = '0;
    blk_abc[31:0]    = 32'h61626380;
    blk_abc[511:480] = 32'h00000018;
    blk_ones = {512{1'b1}};

    rst_n = 1'b0; msg_valid = 1'b0; msg_in = '0; kw_ready = 1'b0;
    @(negedge clk);
    chk("reset_state", 160'({kw_valid, kw_last, kw_quad, kw0_out, kw1_out, kw2_out, kw3_out}), 160'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      kw_ready = i[0];
      #1;
      chk("idle_hygiene", 160'({kw_valid, kw0_out, kw1_out, kw2_out, kw3_out, msg_ready}), 160'(1));
    end

    run(blk_abc, blk_abc, 1, 1'b0);
    model(blk_abc, 0);
    cmp_model("abc", 0);
    for (int i = 0; i < 64; i++) ref_abc[i] = cap[i];
    for (int i = 0; i < 8; i++) chk(vecs[i].name, 160'(cap[vecs[i].t]), 160'(vecs[i].exp));

    run(blk_abc, blk_abc, 1, 1'b1);
    for (int i = 0; i < 64; i++) chk($sformatf("stall_vs_ref%0d", i), 160'(cap[i]), 160'(ref_abc[i]));

    run(blk_ones, blk_ones, 1, 1'b0);
    model(blk_ones, 0);
    cmp_model("ones", 0);
    for (int i = 8; i < 10; i++) chk(vecs[i].name, 160'(cap[vecs[i].t]), 160'(vecs[i].exp));

    run(blk_abc, blk_ones, 2, 1'b0);
    model(blk_abc, 0);
    model(blk_ones, 64);
    cmp_model("b2b_a", 0);
    cmp_model("b2b_b", 64);

    @(negedge clk);
    msg_valid = 1'b1; msg_in = blk_abc; kw_ready = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
    begin
      int n = 0;
      while (!(kw_valid && kw_quad == 4'd7) && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("reach_q7", 160'(kw_quad), 160'(7));
    end
    rst_n = 1'b0;
    #1;
    chk("midreset_outs", 160'({kw_valid, kw_last, kw_quad, kw0_out, kw1_out, kw2_out, kw3_out}), 160'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_ready", 160'({msg_ready, kw_valid}), 160'(2));
    run(blk_ones, blk_ones, 1, 1'b0);
    model(blk_ones, 0);
    cmp_model("after_reset", 0);

    repeat (3) @(negedge clk);
    #1;
    chk("final_idle", 160'({kw_valid, msg_ready}), 160'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
